// File: rtl/riscv_str_unit_pkg.sv
// Shared types and helpers for the string-transform unit (custom opcode 0x0B).
// Op codes 000-011 match the original four-mode string op.
package riscv_str_unit_pkg;

  localparam int unsigned STR_OP_WIDTH = 3;
  localparam int unsigned ROT_W        = 5;
  localparam int unsigned ALPHA_N      = 26;

  typedef enum logic [STR_OP_WIDTH-1:0] {
    STR_OP_UPPER  = 3'b000,
    STR_OP_LOWER  = 3'b001,
    STR_OP_LEET   = 3'b010,
    STR_OP_ROT13  = 3'b011,
    STR_OP_ROTN   = 3'b100,
    STR_OP_TOGGLE = 3'b101,
    STR_OP_TITLE  = 3'b110,
    STR_OP_RSVD   = 3'b111
  } str_op_e;

  // Per-beat control captured alongside the data in S1
  typedef struct packed {
    str_op_e          op;
    logic [ROT_W-1:0] rot;
    logic             first;
    logic             last;
  } str_ctrl_t;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

  function automatic logic is_alpha(input logic [7:0] c);
    return is_upper(c) || is_lower(c);
  endfunction

  // A 5-bit amount is below 52, so one conditional subtract gives mod 26
  function automatic logic [ROT_W-1:0] rot_reduce(input logic [ROT_W-1:0] r);
    return (r >= ROT_W'(ALPHA_N)) ? r - ROT_W'(ALPHA_N) : r;
  endfunction

endpackage

// File: rtl/riscv_str_unit_if.sv
// Operand/op handshake from ID and result handshake toward writeback.
interface riscv_str_unit_if #(
  parameter int unsigned NUM_BYTES = 4,
  parameter int unsigned COUNT_W   = 16
);
  localparam int unsigned DATA_W = 8 * NUM_BYTES;

  logic                                       in_valid;
  logic                                       in_ready;
  logic [DATA_W-1:0]                          in_data;
  logic [riscv_str_unit_pkg::STR_OP_WIDTH-1:0] in_op;
  logic [riscv_str_unit_pkg::ROT_W-1:0]        in_rot;
  logic                                       in_first;
  logic                                       in_last;

  logic                                       out_valid;
  logic                                       out_ready;
  logic [DATA_W-1:0]                          out_data;
  logic                                       out_last;
  logic                                       out_illegal;
  logic [COUNT_W-1:0]                         out_count;

  modport master (
    output in_valid, in_data, in_op, in_rot, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_illegal, out_count
  );

  modport slave (
    input  in_valid, in_data, in_op, in_rot, in_first, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_illegal, out_count
  );

endinterface

// File: rtl/riscv_str_byte_xform.sv
// Single-character transform: one byte in, transformed byte and changed flag out.
module riscv_str_byte_xform
  import riscv_str_unit_pkg::*;
(
  input  logic [7:0]       byte_i,
  input  str_op_e          op_i,
  input  logic [ROT_W-1:0] rot_i,
  input  logic             prev_alpha_i,
  output logic [7:0]       byte_o,
  output logic             changed_o
);

  logic             upper;
  logic             lower;
  logic             alpha;
  logic [7:0]       folded;
  logic [7:0]       base;
  logic [ROT_W-1:0] amt;
  logic [5:0]       idx;
  logic [5:0]       sum;
  logic [7:0]       rotated;

  // Rotation stays inside the letter's own case; idx is only meaningful for letters
  always_comb begin
    upper   = is_upper(byte_i);
    lower   = is_lower(byte_i);
    alpha   = upper || lower;
    folded  = byte_i | 8'h20;
    base    = upper ? 8'h41 : 8'h61;
    amt     = (op_i == STR_OP_ROT13) ? ROT_W'(13) : rot_i;
    idx     = 6'(byte_i - base);
    sum     = idx + 6'(amt);
    if (sum >= 6'(ALPHA_N)) begin
      sum = sum - 6'(ALPHA_N);
    end
    rotated = base + 8'(sum);
  end

  always_comb begin
    byte_o = byte_i;
    if (alpha) begin
      case (op_i)
        STR_OP_UPPER:  if (lower) byte_o = byte_i ^ 8'h20;
        STR_OP_LOWER:  if (upper) byte_o = byte_i ^ 8'h20;
        STR_OP_LEET: begin
          case (folded)
            8'h61:   byte_o = 8'h34;
            8'h65:   byte_o = 8'h33;
            8'h69:   byte_o = 8'h31;
            8'h6F:   byte_o = 8'h30;
            8'h73:   byte_o = 8'h35;
            8'h74:   byte_o = 8'h37;
            default: byte_o = byte_i;
          endcase
        end
        STR_OP_ROT13,
        STR_OP_ROTN:   byte_o = rotated;
        STR_OP_TOGGLE: byte_o = byte_i ^ 8'h20;
        STR_OP_TITLE:  byte_o = prev_alpha_i ? folded : (byte_i & 8'hDF);
        default:       byte_o = byte_i;
      endcase
    end
    changed_o = (byte_o != byte_i);
  end

endmodule

// File: rtl/riscv_str_unit.sv
// Two-stage pipelined multi-lane string-transform unit beside the EX-stage ALU.
// S1 captures the beat and per-byte context; S2 holds the result and stream count.
module riscv_str_unit
  import riscv_str_unit_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4,
  parameter int unsigned COUNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  riscv_str_unit_if.slave   bus
);

  localparam int unsigned DATA_W = 8 * NUM_BYTES;
  localparam int unsigned BCNT_W = $clog2(NUM_BYTES + 1);
  localparam int unsigned SUM_W  = COUNT_W + 1;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic                 s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]    s1_data_q, s1_data_d;
  str_ctrl_t            s1_ctrl_q, s1_ctrl_d;
  logic [NUM_BYTES-1:0] s1_prev_q, s1_prev_d;
  logic                 prev_alpha_q, prev_alpha_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 out_illegal_q, out_illegal_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic                 s2_load;
  logic                 accept;
  logic [DATA_W-1:0]    xf_data;
  logic [NUM_BYTES-1:0] xf_changed;
  logic [BCNT_W-1:0]    beat_cnt;
  logic [SUM_W-1:0]     cnt_sum;

  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign bus.in_ready = !rst && (!s1_valid_q || s2_load);
  assign accept       = bus.in_valid && bus.in_ready;

  // S1: capture beat, reduce rotate amount, resolve each byte's preceding-letter flag
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_ctrl_d    = s1_ctrl_q;
    s1_prev_d    = s1_prev_q;
    prev_alpha_d = prev_alpha_q;
    if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (accept) begin
      s1_valid_d      = 1'b1;
      s1_data_d       = bus.in_data;
      s1_ctrl_d.op    = str_op_e'(bus.in_op);
      s1_ctrl_d.rot   = rot_reduce(bus.in_rot);
      s1_ctrl_d.first = bus.in_first;
      s1_ctrl_d.last  = bus.in_last;
      s1_prev_d[0]    = !bus.in_first && prev_alpha_q;
      for (int unsigned k = 1; k < NUM_BYTES; k++) begin
        s1_prev_d[k] = is_alpha(bus.in_data[8*(k-1) +: 8]);
      end
      prev_alpha_d = is_alpha(bus.in_data[DATA_W-8 +: 8]);
    end
  end

  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_lane
    riscv_str_byte_xform u_xform (
      .byte_i       (s1_data_q[8*k +: 8]),
      .op_i         (s1_ctrl_q.op),
      .rot_i        (s1_ctrl_q.rot),
      .prev_alpha_i (s1_prev_q[k]),
      .byte_o       (xf_data[8*k +: 8]),
      .changed_o    (xf_changed[k])
    );
  end

  always_comb begin
    beat_cnt = '0;
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      beat_cnt = beat_cnt + BCNT_W'(xf_changed[k]);
    end
  end

  // S2: result register and saturating per-stream changed-character count
  always_comb begin
    s2_valid_d    = s2_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    out_illegal_d = out_illegal_q;
    count_d       = count_q;
    cnt_sum       = SUM_W'(count_q) + SUM_W'(beat_cnt);
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d    = xf_data;
        out_last_d    = s1_ctrl_q.last;
        out_illegal_d = (s1_ctrl_q.op == STR_OP_RSVD);
        if (s1_ctrl_q.first) begin
          count_d = COUNT_W'(beat_cnt);
        end else if (cnt_sum[COUNT_W]) begin
          count_d = COUNT_MAX;
        end else begin
          count_d = cnt_sum[COUNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_data_q     <= '0;
      s1_ctrl_q     <= '0;
      s1_prev_q     <= '0;
      prev_alpha_q  <= 1'b0;
      s2_valid_q    <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      out_illegal_q <= 1'b0;
      count_q       <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_data_q     <= s1_data_d;
      s1_ctrl_q     <= s1_ctrl_d;
      s1_prev_q     <= s1_prev_d;
      prev_alpha_q  <= prev_alpha_d;
      s2_valid_q    <= s2_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      out_illegal_q <= out_illegal_d;
      count_q       <= count_d;
    end
  end

  assign bus.out_valid   = s2_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_last    = out_last_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.out_count   = count_q;

endmodule

// File: tb/tb_riscv_str_unit.sv
// Scoreboard bench for riscv_str_unit: directed beats push expectations, a monitor pops and compares.
module tb_riscv_str_unit;
  import riscv_str_unit_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_str_unit_if #(.NUM_BYTES(NB), .COUNT_W(CW)) bus ();

  riscv_str_unit #(.NUM_BYTES(NB), .COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        last;
    logic        illegal;
    logic [15:0] count;
    bit          chk_cnt;
    bit          chk_lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compare every output handshake against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%08h expected none", bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("data[%0d]", e.id), bus.out_data, e.data);
        chk($sformatf("last[%0d]", e.id), 32'(bus.out_last), 32'(e.last));
        chk($sformatf("illegal[%0d]", e.id), 32'(bus.out_illegal), 32'(e.illegal));
        if (e.chk_cnt) chk($sformatf("count[%0d]", e.id), 32'(bus.out_count), 32'(e.count));
        if (e.chk_lat) chk($sformatf("latency[%0d]", e.id), 32'(cyc - e.acc_cyc), 32'd2);
      end
    end
  end

  task automatic send(input int id, input logic [31:0] d, input str_op_e op, input logic [4:0] rot,
                      input logic first, input logic last, input logic [31:0] ed,
                      input logic [15:0] ec, input bit cc, input bit cl);
    exp_t e;
    int   w;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_op    = op;
    bus.in_rot   = rot;
    bus.in_first = first;
    bus.in_last  = last;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.in_ready && w < 100);
    if (!bus.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout[%0d]: got in_ready=0 expected acceptance", id);
    end else begin
      e.id      = id;
      e.data    = ed;
      e.last    = last;
      e.illegal = (op == STR_OP_RSVD);
      e.count   = ec;
      e.chk_cnt = cc;
      e.chk_lat = cl;
      e.acc_cyc = cyc;
      sb.push_back(e);
      n_acc++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int id);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout[%0d]: got %0d pending expected 0", id, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    int          base;
    int          w;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_op    = '0;
    bus.in_rot   = '0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_count", 32'(bus.out_count), 32'd0);
    rst = 1'b0;

    // Directed functional beats, no backpressure
    send(1,  32'h6C6C6548, STR_OP_UPPER,  5'd0,  1, 1, 32'h4C4C4548, 16'd3, 1, 1);
    send(2,  32'h7A636261, STR_OP_ROT13,  5'd0,  1, 1, 32'h6D706F6E, 16'd4, 1, 1);
    send(3,  32'h217A7978, STR_OP_ROTN,   5'd29, 1, 1, 32'h21636261, 16'd3, 1, 1);
    send(4,  32'h4C4C6568, STR_OP_TITLE,  5'd0,  1, 0, 32'h6C6C6548, 16'd0, 0, 1);
    send(5,  32'h6F77206F, STR_OP_TITLE,  5'd0,  0, 1, 32'h6F57206F, 16'd4, 1, 1);
    send(6,  32'h74736574, STR_OP_LEET,   5'd0,  1, 1, 32'h37353337, 16'd4, 1, 1);
    send(7,  32'h45544953, STR_OP_LEET,   5'd0,  1, 1, 32'h33373135, 16'd4, 1, 1);
    send(8,  32'h00006241, STR_OP_TOGGLE, 5'd0,  1, 1, 32'h00004261, 16'd2, 1, 1);
    send(9,  32'h6C6C6548, STR_OP_RSVD,   5'd0,  1, 1, 32'h6C6C6548, 16'd0, 1, 1);
    send(10, 32'h4F4C4548, STR_OP_LOWER,  5'd0,  1, 1, 32'h6F6C6568, 16'd4, 1, 1);
    send(11, 32'h7B605B40, STR_OP_UPPER,  5'd0,  1, 1, 32'h7B605B40, 16'd0, 1, 1);
    send(12, 32'h00005A61, STR_OP_ROTN,   5'd25, 1, 1, 32'h0000597A, 16'd2, 1, 1);
    send(13, 32'h00000061, STR_OP_ROTN,   5'd31, 1, 1, 32'h00000066, 16'd1, 1, 1);
    drain(1);

    // Backpressure: only two beats fit while the output is stalled
    bus.out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        send(20, 32'h64636261, STR_OP_UPPER, 5'd0, 1, 1, 32'h44434241, 16'd4, 1, 0);
        send(21, 32'h32623161, STR_OP_UPPER, 5'd0, 1, 1, 32'h32423141, 16'd2, 1, 0);
        send(22, 32'h775A5958, STR_OP_UPPER, 5'd0, 1, 1, 32'h575A5958, 16'd1, 1, 0);
        send(23, 32'h21217A7A, STR_OP_UPPER, 5'd0, 1, 1, 32'h21215A5A, 16'd2, 1, 0);
      end
    join_none
    repeat (3) @(negedge clk);
    held = bus.out_data;
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_head_data", held, 32'h44434241);
    repeat (3) begin
      @(negedge clk);
      chk("bp_stable_data", bus.out_data, held);
    end
    #1;
    chk("bp_accepted", 32'(n_acc - base), 32'd2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    w = 0;
    while ((n_acc - base) < 4 && w < 60) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("bp_all_accepted", 32'(n_acc - base), 32'd4);
    drain(2);

    // Reset with two beats in flight, then a TITLE continuation beat
    bus.out_ready = 1'b0;
    send(30, 32'h6C6F6F74, STR_OP_LEET,  5'd0, 1, 1, 32'h6C303037, 16'd3, 1, 0);
    send(31, 32'h6B636F6C, STR_OP_UPPER, 5'd0, 1, 1, 32'h4B434F4C, 16'd4, 1, 0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_count", 32'(bus.out_count), 32'd0);
    chk("mid_rst_out_data", bus.out_data, 32'd0);
    chk("mid_rst_out_last", 32'(bus.out_last), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(32, 32'h20636261, STR_OP_TITLE, 5'd0, 0, 1, 32'h20636241, 16'd1, 1, 1);
    drain(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_str_unit.md
Name: riscv_str_unit

Overview:
- Pipelined multi-lane string-transform unit for the custom string-op opcode (0x0B). Successor to the single-word, four-mode string op.
- Processes NUM_BYTES ASCII characters per beat under valid/ready handshakes. Adds rotate-by-N, case toggle and title-case modes. Title case carries state across beats of a stream.
- Counts changed characters per stream. Sits beside the ALU in EX and is fed from ID through an operand/op handshake.

Parameters:
- NUM_BYTES, 4, characters per beat; data width is 8*NUM_BYTES.
- COUNT_W, 16, width of the per-stream changed-character counter; the counter saturates.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  8*NUM_BYTES  characters; byte 0 (bits 7:0) is the earliest character
- in_op  in  3  STR_OP_* code
- in_rot  in  5  rotate amount for ROTN
- in_first  in  1  first beat of a stream
- in_last  in  1  last beat of a stream
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  8*NUM_BYTES  transformed characters
- out_last  out  1  in_last delayed with its beat
- out_illegal  out  1  beat carried a reserved op
- out_count  out  COUNT_W  changed characters in the stream; meaningful only when out_last=1

Behaviour:
- Op codes: 000 UPPER, 001 LOWER, 010 LEET, 011 ROT13, 100 ROTN, 101 TOGGLE, 110 TITLE, 111 reserved.
- Reserved op: data passes through unchanged, out_illegal=1, and no bytes are counted.
- Only bytes 0x41-0x5A and 0x61-0x7A are letters. All other bytes pass through unchanged in every mode.
- LEET map (either case): a→'4', e→'3', i→'1', o→'0', s→'5', t→'7'. Every other letter is unchanged.
- ROT13 and ROTN rotate within the letter's own case, modulo 26.
- ROTN effective amount = in_rot if in_rot<26, else in_rot−26.
- TOGGLE flips the case of each letter.
- TITLE: a letter is uppercased if the preceding character is a non-letter, otherwise lowercased.
  - Within a beat, the preceding character of byte k is byte k−1.
  - The preceding character of byte 0 is the last byte of the previous accepted beat.
  - On an in_first beat, the preceding character counts as a non-letter.
  - A state flop prev_alpha is updated on every accepted beat of any op. It is cleared by rst.
- Changed count: a byte counts if output byte != input byte.
  - The counter loads this beat's count on an accepted in_first beat. Otherwise it adds this beat's count, saturating at 2^COUNT_W−1.
  - out_count shows the total including the current beat.
  - in_first && in_last together form a single-beat stream.
- Pipeline: two register stages.
  - S1 captures input, reduces the rotate amount, and computes per-byte preceding-alpha flags.
  - S2 holds the transformed result and count.
  - Latency is exactly 2 cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Stall rules:
  - S2 loads when !s2_valid || out_ready.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || S2 loads.
  - in_ready = 0 while rst=1.
- While out_valid && !out_ready, all out_* signals hold stable. A full pipeline holds 2 beats before in_ready drops.
- Reset, including mid-stream: s1_valid, s2_valid, out_valid, out_last, out_illegal, prev_alpha, counter, out_data and out_count all return to 0. In-flight beats are dropped.
- A beat without in_first after reset is treated as a stream continuation, using prev_alpha=0 and counter=0.

Decomposition:
- riscv_defines additions:
  - Widen STR_OP_WIDTH to 3; existing codes 000-011 are unchanged.
  - Add STR_OP_ROTN=3'b100, STR_OP_TOGGLE=3'b101, STR_OP_TITLE=3'b110, STR_OP_RSVD=3'b111.
- Sub-module riscv_str_byte_xform: combinational, one byte plus op, rotate amount and prev_alpha in; byte plus changed flag out. Instantiated NUM_BYTES times in S2.

Test Plan:
- UPPER, first+last, data 0x6C6C6548 ("Hell") → out 0x4C4C4548, out_count=3, latency 2 cycles.
- ROT13 on 0x7A636261 ("abcz") → 0x6D706F6E ("nopm"). ROTN with in_rot=29 on 0x217A7978 ("xyz!") → 0x21636261 ("abc!").
- TITLE two-beat stream:
  - Beat 1: 0x4C4C6568 ("heLL", first) → 0x6C6C6548.
  - Beat 2: 0x6F77206F ("o wo", last) → 0x6F57206F.
  - out_count=4 on beat 2.
- LEET on 0x74736574 ("test") → 0x37353337; TOGGLE on 0x6241 → 0x4261; op 111 → data unchanged, out_illegal=1, count 0.
- Backpressure:
  - With out_ready=0 for 5 cycles and in_valid=1 continuously, exactly 2 beats are accepted, then in_ready=0 and out_data stays stable.
  - On release, beats emerge in order with no loss or duplication.
- Assert rst while 2 beats are in flight → next cycle out_valid=0 and out_count=0. A following TITLE beat without in_first uppercases byte 0 if it is a letter.
